apb_access_scheduler: RTL and testbench
=======================================

APB_ACCESS_SCHEDULER -- requirements
Module: apb_access_scheduler

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, meaning address width of requests and issued beats.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-004 SHALL have port rd_req_valid  input  1  AXI reader has a read burst pending.
REQ-005 SHALL have port rd_req_info  input  ADDR_WIDTH+9  read burst {addr, len[3:0], size[2:0], burst[1:0]}.
REQ-006 SHALL have port rd_req_ready  output  1  read burst accepted this cycle.
REQ-007 SHALL have port wr_req_valid  input  1  AXI writer has a write burst pending (address and data buffered).
REQ-008 SHALL have port wr_req_info  input  ADDR_WIDTH+9  write burst, same packing as rd_req_info.
REQ-009 SHALL have port wr_req_ready  output  1  write burst accepted this cycle.
REQ-010 SHALL have port apb_cmd_valid  output  1  beat command presented to the APB engine.
REQ-011 SHALL have port apb_cmd  output  2  00 DISABLE, 01 READ, 10 WRITE.
REQ-012 SHALL have port apb_addr  output  ADDR_WIDTH  address of the current beat.
REQ-013 SHALL have port apb_last  output  1  current beat is the final beat of its burst.
REQ-014 SHALL have port apb_cmd_ready  input  1  APB engine accepted the beat command.
REQ-015 SHALL have port apb_beat_done  input  1  APB engine completed the beat (PREADY seen).
REQ-016 SHALL have port rd_done  output  1  one-cycle pulse when a read burst completes.
REQ-017 SHALL have port wr_done  output  1  one-cycle pulse when a write burst completes.
REQ-018 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE: if any *_req_valid, SHALL select one requester, pulse its *_req_ready for that cycle, latch its info, clear beat_cnt, and go to ISSUE.
REQ-021 Arbitration SHALL be round-robin: when both requests are valid, the requester not granted last wins; when only one is valid, it wins.
REQ-022 ISSUE: SHALL drive apb_cmd_valid=1, apb_cmd per the granted requester, apb_addr=current address, apb_last=(beat_cnt==len); on apb_cmd_ready SHALL go to WAIT.
REQ-023 WAIT: apb_cmd_valid SHALL be 0 and apb_cmd SHALL hold its value; on apb_beat_done with beat_cnt==len SHALL go to DONE; otherwise SHALL increment beat_cnt, update the address, and go to ISSUE.
REQ-024 DONE: SHALL pulse rd_done or wr_done for exactly one cycle, record the last grant, and return to IDLE; no new grant SHALL occur in DONE.
REQ-025 Beats per burst SHALL be len+1 (1..16); beat_cnt SHALL be 4 bits.
REQ-026 burst=00 (FIXED): the address SHALL stay constant; burst=01 (INCR), 10 and 11: the address SHALL increase by 2^size, modulo 2^ADDR_WIDTH (silent wrap-around).
REQ-027 apb_beat_done SHALL be ignored outside WAIT; apb_cmd_ready SHALL be ignored outside ISSUE.
REQ-028 Request inputs SHALL be sampled only in IDLE; a change in the info of a request already accepted SHALL not affect the burst in flight.
REQ-029 Minimum burst latency SHALL be 1 (grant) + 2 per beat (ISSUE, WAIT) + 1 (DONE) cycles, assuming zero-wait APB.

Reset
REQ-030 On rst assertion, asynchronously: state=IDLE, beat_cnt=0, address=0, last grant=WRITE (read wins the first tie), and all outputs 0 (apb_cmd=DISABLE).
REQ-031 Reset mid-burst SHALL abandon the burst with no done pulse; the first rising edge after deassertion SHALL be able to grant.

Verification
REQ-032 Single read: addr=0x1000, len=3, size=2, INCR -> apb_addr 0x1000,0x1004,0x1008,0x100C as READ; apb_last only on 0x100C; rd_done pulses once.
REQ-033 Simultaneous read and write, both held valid for 3 bursts -> grant order R,W,R after reset; each *_req_ready is a single-cycle pulse.
REQ-034 FIXED write: addr=0x20, len=2 -> three WRITE beats, all at 0x20, followed by a single wr_done.
REQ-035 Wrap: addr=0xFFFFFFFC, len=1, size=2, INCR -> beats at 0xFFFFFFFC then 0x00000000.
REQ-036 APB stall: apb_cmd_ready low for 5 cycles, then apb_beat_done delayed 4 cycles -> command and address held stable; no beat skipped or duplicated.
REQ-037 rst asserted in WAIT of beat 2 of 4 -> outputs 0 immediately, no done pulse; a pending write is granted on the first edge after reset release.

Source files
------------

// File: rtl/apb_access_scheduler.sv
// Arbitrates AXI read/write bursts round-robin and walks each accepted burst
// out as single APB beat commands, one command in flight at a time.
module apb_access_scheduler #(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req_valid,
  input  logic [ADDR_WIDTH+8:0] rd_req_info,
  output logic                  rd_req_ready,
  input  logic                  wr_req_valid,
  input  logic [ADDR_WIDTH+8:0] wr_req_info,
  output logic                  wr_req_ready,
  output logic                  apb_cmd_valid,
  output logic [1:0]            apb_cmd,
  output logic [ADDR_WIDTH-1:0] apb_addr,
  output logic                  apb_last,
  input  logic                  apb_cmd_ready,
  input  logic                  apb_beat_done,
  output logic                  rd_done,
  output logic                  wr_done,
  output logic                  busy
);

  localparam int INFO_W = ADDR_WIDTH + 9;

  localparam logic [1:0] CMD_DISABLE = 2'b00;
  localparam logic [1:0] CMD_READ    = 2'b01;
  localparam logic [1:0] CMD_WRITE   = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            beat_cnt_q, beat_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [3:0]            len_q, len_d;
  logic [2:0]            size_q, size_d;
  logic [1:0]            burst_q, burst_d;
  logic                  gnt_wr_q, gnt_wr_d;
  logic                  last_wr_q, last_wr_d;

  logic                  grant_rd;
  logic                  grant_wr;
  logic                  last_beat;
  logic [INFO_W-1:0]     sel_info;

  // FIXED bursts replay one address; all other burst types step by 2^size.
  function automatic logic [ADDR_WIDTH-1:0] next_addr(
    input logic [ADDR_WIDTH-1:0] addr,
    input logic [2:0]            size,
    input logic [1:0]            burst
  );
    if (burst == 2'b00) begin
      return addr;
    end
    return addr + (ADDR_WIDTH'(1) << size);
  endfunction

  // Read wins a tie unless it was the previous grant.
  assign grant_rd  = rd_req_valid && (!wr_req_valid || last_wr_q);
  assign grant_wr  = wr_req_valid && !grant_rd;
  assign sel_info  = grant_rd ? rd_req_info : wr_req_info;
  assign last_beat = (beat_cnt_q == len_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      beat_cnt_q <= 4'd0;
      addr_q     <= '0;
      len_q      <= 4'd0;
      size_q     <= 3'd0;
      burst_q    <= 2'd0;
      gnt_wr_q   <= 1'b0;
      last_wr_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      addr_q     <= addr_d;
      len_q      <= len_d;
      size_q     <= size_d;
      burst_q    <= burst_d;
      gnt_wr_q   <= gnt_wr_d;
      last_wr_q  <= last_wr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    size_d     = size_q;
    burst_d    = burst_q;
    gnt_wr_d   = gnt_wr_q;
    last_wr_d  = last_wr_q;
    unique case (state_q)
      S_IDLE: begin
        if (grant_rd || grant_wr) begin
          addr_d     = sel_info[INFO_W-1:9];
          len_d      = sel_info[8:5];
          size_d     = sel_info[4:2];
          burst_d    = sel_info[1:0];
          gnt_wr_d   = grant_wr;
          beat_cnt_d = 4'd0;
          state_d    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (apb_cmd_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (apb_beat_done) begin
          if (last_beat) begin
            state_d = S_DONE;
          end else begin
            beat_cnt_d = beat_cnt_q + 4'd1;
            addr_d     = next_addr(addr_q, size_q, burst_q);
            state_d    = S_ISSUE;
          end
        end
      end
      S_DONE: begin
        last_wr_d = gnt_wr_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Grants are combinational from IDLE; held off while reset is asserted.
  always_comb begin
    rd_req_ready  = 1'b0;
    wr_req_ready  = 1'b0;
    apb_cmd_valid = 1'b0;
    apb_cmd       = CMD_DISABLE;
    apb_last      = 1'b0;
    rd_done       = 1'b0;
    wr_done       = 1'b0;
    apb_addr      = addr_q;
    busy          = (state_q != S_IDLE);
    unique case (state_q)
      S_IDLE: begin
        rd_req_ready = grant_rd && !rst;
        wr_req_ready = grant_wr && !rst;
      end
      S_ISSUE: begin
        apb_cmd_valid = 1'b1;
        apb_cmd       = gnt_wr_q ? CMD_WRITE : CMD_READ;
        apb_last      = last_beat;
      end
      S_WAIT: begin
        apb_cmd  = gnt_wr_q ? CMD_WRITE : CMD_READ;
        apb_last = last_beat;
      end
      S_DONE: begin
        rd_done = !gnt_wr_q;
        wr_done = gnt_wr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_apb_access_scheduler.sv
// Directed and randomized bench for apb_access_scheduler, checked against a
// burst-level model of arbitration and beat address generation.
module tb_apb_access_scheduler;

  localparam int AW = 32;
  localparam int IW = AW + 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req_valid;
  logic [IW-1:0] rd_req_info;
  logic          rd_req_ready;
  logic          wr_req_valid;
  logic [IW-1:0] wr_req_info;
  logic          wr_req_ready;
  logic          apb_cmd_valid;
  logic [1:0]    apb_cmd;
  logic [AW-1:0] apb_addr;
  logic          apb_last;
  logic          apb_cmd_ready;
  logic          apb_beat_done;
  logic          rd_done;
  logic          wr_done;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;
  bit m_last_wr = 1'b1;

  apb_access_scheduler #(.ADDR_WIDTH(AW)) dut (
    .clk           (clk),
    .rst           (rst),
    .rd_req_valid  (rd_req_valid),
    .rd_req_info   (rd_req_info),
    .rd_req_ready  (rd_req_ready),
    .wr_req_valid  (wr_req_valid),
    .wr_req_info   (wr_req_info),
    .wr_req_ready  (wr_req_ready),
    .apb_cmd_valid (apb_cmd_valid),
    .apb_cmd       (apb_cmd),
    .apb_addr      (apb_addr),
    .apb_last      (apb_last),
    .apb_cmd_ready (apb_cmd_ready),
    .apb_beat_done (apb_beat_done),
    .rd_done       (rd_done),
    .wr_done       (wr_done),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] mk(input logic [31:0] a, input int len, input int sz, input int bt);
    return {a, 4'(len), 3'(sz), 2'(bt)};
  endfunction

  function automatic logic [IW-1:0] rnd_info();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[IW-1:0];
  endfunction

  // One burst from grant to done. cs/ds: stall cycles before cmd_ready and
  // beat_done; hold keeps the winner's request up; noise toggles the inputs
  // that must be ignored; rst_beat aborts with reset in that beat's WAIT.
  task automatic serve(input int cs, input int ds, input bit hold, input bit noise,
                       input int rst_beat, output bit gw);
    int            waited;
    bit            rv, wv, exp_wr;
    logic [IW-1:0] inf;
    logic [31:0]   base, step, ea;
    logic [3:0]    len;
    logic [1:0]    ecmd;
    waited = 0;
    gw = 1'b0;
    @(negedge clk);
    while (!(rd_req_ready || wr_req_ready) && waited < 20) begin
      waited++;
      @(negedge clk);
    end
    chk("grant_latency", 64'(waited), 64'd0);
    if (waited >= 20) return;
    rv = rd_req_valid;
    wv = wr_req_valid;
    if (rv && wv) exp_wr = !m_last_wr;
    else          exp_wr = wv;
    gw = wr_req_ready;
    chk("grant_is_wr", 64'(wr_req_ready), 64'(exp_wr));
    chk("grant_one_hot", 64'(rd_req_ready && wr_req_ready), 64'd0);
    chk("idle_status", {61'd0, busy, rd_done, wr_done}, 64'd0);
    inf  = exp_wr ? wr_req_info : rd_req_info;
    base = inf[IW-1:9];
    len  = inf[8:5];
    step = (inf[1:0] == 2'b00) ? 32'd0 : (32'd1 << inf[4:2]);
    ecmd = exp_wr ? 2'b10 : 2'b01;
    for (int i = 0; i <= int'(len); i++) begin
      ea = base + step * 32'(i);
      for (int s = 0; s <= cs; s++) begin
        @(negedge clk);
        chk("issue_valid", 64'(apb_cmd_valid), 64'd1);
        chk("issue_cmd", 64'(apb_cmd), 64'(ecmd));
        chk("issue_addr", 64'(apb_addr), 64'(ea));
        chk("issue_last", 64'(apb_last), 64'(i == int'(len)));
        if (i == 0 && s == 0) begin
          chk("ready_pulse", {62'd0, rd_req_ready, wr_req_ready}, 64'd0);
          if (!hold) begin
            if (exp_wr) begin wr_req_valid = 1'b0; wr_req_info = rnd_info(); end
            else        begin rd_req_valid = 1'b0; rd_req_info = rnd_info(); end
          end
        end
        apb_cmd_ready = (s == cs);
        apb_beat_done = noise ? 1'($urandom) : 1'b0;
      end
      for (int s = 0; s <= ds; s++) begin
        @(negedge clk);
        chk("wait_valid", 64'(apb_cmd_valid), 64'd0);
        chk("wait_cmd", 64'(apb_cmd), 64'(ecmd));
        chk("wait_addr", 64'(apb_addr), 64'(ea));
        chk("wait_busy", 64'(busy), 64'd1);
        if (i == rst_beat && s == 0) begin
          #1 rst = 1'b1;
          #1;
          chk("rst_outputs", {apb_cmd_valid, apb_cmd, apb_addr, apb_last, rd_done, wr_done,
                              busy, rd_req_ready, wr_req_ready}, 64'd0);
          apb_cmd_ready = 1'b0;
          apb_beat_done = 1'b0;
          @(negedge clk);
          chk("rst_no_done", {62'd0, rd_done, wr_done}, 64'd0);
          @(posedge clk);
          #1 rst = 1'b0;
          m_last_wr = 1'b1;
          return;
        end
        apb_beat_done = (s == ds);
        apb_cmd_ready = noise ? 1'($urandom) : 1'b0;
      end
    end
    @(negedge clk);
    chk("done_rd", 64'(rd_done), 64'(!exp_wr));
    chk("done_wr", 64'(wr_done), 64'(exp_wr));
    chk("done_status", {61'd0, busy, apb_cmd_valid, rd_req_ready || wr_req_ready}, 64'd4);
    apb_cmd_ready = 1'b0;
    apb_beat_done = 1'b0;
    m_last_wr = exp_wr;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    m_last_wr = 1'b1;
  endtask

  initial begin
    bit g1, g2, g3;
    rst = 1'b1;
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    rd_req_info = '0;
    wr_req_info = '0;
    apb_cmd_ready = 1'b0;
    apb_beat_done = 1'b0;
    #1;
    chk("reset_outputs", {apb_cmd_valid, apb_cmd, apb_addr, apb_last, rd_done, wr_done,
                          busy, rd_req_ready, wr_req_ready}, 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Single INCR read
    rd_req_valid = 1'b1;
    rd_req_info  = mk(32'h1000, 3, 2, 1);
    serve(0, 0, 0, 0, -1, g1);
    chk("single_read_grant", 64'(g1), 64'd0);

    // Round-robin with both requests held
    do_reset();
    rd_req_valid = 1'b1; rd_req_info = mk(32'h2000, 0, 2, 1);
    wr_req_valid = 1'b1; wr_req_info = mk(32'h3000, 1, 1, 1);
    serve(0, 0, 1, 0, -1, g1);
    serve(0, 0, 1, 0, -1, g2);
    serve(0, 0, 1, 0, -1, g3);
    chk("rr_order", {61'd0, g1, g2, g3}, 64'b010);
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;

    // FIXED write
    wr_req_valid = 1'b1; wr_req_info = mk(32'h20, 2, 2, 0);
    serve(0, 0, 0, 0, -1, g1);

    // Address wrap-around
    rd_req_valid = 1'b1; rd_req_info = mk(32'hFFFF_FFFC, 1, 2, 1);
    serve(0, 0, 0, 0, -1, g1);

    // APB stall
    wr_req_valid = 1'b1; wr_req_info = mk(32'h400, 1, 3, 1);
    serve(5, 4, 0, 1, -1, g1);

    // Reset during WAIT of beat 2 of 4, write pending
    rd_req_valid = 1'b1; rd_req_info = mk(32'h5000, 3, 2, 1);
    wr_req_valid = 1'b1; wr_req_info = mk(32'h6000, 0, 2, 1);
    serve(0, 0, 0, 0, 1, g1);
    serve(0, 0, 0, 0, -1, g2);
    chk("post_reset_write", {62'd0, g1, g2}, 64'b01);

    // Randomized bursts
    for (int k = 0; k < 30; k++) begin
      rd_req_valid = 1'($urandom);
      wr_req_valid = 1'($urandom);
      if (!rd_req_valid && !wr_req_valid) rd_req_valid = 1'b1;
      rd_req_info = rnd_info();
      wr_req_info = rnd_info();
      serve(int'($urandom_range(2, 0)), int'($urandom_range(2, 0)), 1'b0, 1'b1, -1, g1);
    end
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
